// File: rtl/dec_key_sched.sv
// dec_key_sched: buffers encryption round keys and replays them in reverse, theta-mixed, as decryption keys
module dec_key_sched #(
  parameter int ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [127:0] wr_key,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [127:0] rd_key,
  output logic         rd_last
);
  localparam int CW = $clog2(ROUNDS + 2);
  typedef enum logic {LOAD, DRAIN} state_t;
  state_t state, state_nx;
  logic [127:0] mem [0:ROUNDS];
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic wr_fire, rd_fire, wr_final;
  logic [127:0] next_key;
  function automatic logic [7:0] x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [1:0] s);
    logic [7:0] a2, a4;
    a2 = x2(a);
    a4 = x2(a2);
    return s == 2'd0 ? a : s == 2'd1 ? a2 : s == 2'd2 ? a4 : a4 ^ a2;
  endfunction
  function automatic logic [127:0] theta(input logic [127:0] d);
    logic [127:0] r;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        b = '0;
        for (int k = 0; k < 4; k++)
          b ^= gmul(d[127-8*(4*i+k) -: 8], 2'(k ^ j));
        r[127-8*(4*i+j) -: 8] = b;
      end
    return r;
  endfunction
  assign wr_ready = state == LOAD;
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;
  assign wr_final = wr_cnt == CW'(ROUNDS);
  assign next_key = rd_cnt == '0 ? mem[0] : theta(mem[rd_cnt]);
  always_comb begin
    state_nx = state;
    state_nx = flush ? LOAD :
               (state == LOAD && wr_fire && wr_final) ? DRAIN :
               (state == DRAIN && rd_fire && rd_last) ? LOAD : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= LOAD;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (rst_n && !flush && wr_fire) mem[wr_cnt] <= wr_key;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_key   <= '0;
      rd_last  <= 1'b0;
    end else if (flush) begin
      wr_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_final) begin
        rd_key   <= wr_key;
        rd_valid <= 1'b1;
        rd_cnt   <= CW'(ROUNDS - 1);
        rd_last  <= 1'b0;
      end
    end else if (rd_fire) begin
      if (rd_last) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
        wr_cnt   <= '0;
      end else begin
        rd_key  <= next_key;
        rd_last <= rd_cnt == '0;
        rd_cnt  <= rd_cnt - 1'b1;
      end
    end
endmodule
